clock_mode_ctrl: RTL and testbench

Top-level mode controller for the digital clock. It owns the shared mode/increment/set buttons and decides which field-setter gets them: the time setter, the alarm setter, or neither. It also compares the running time against the stored alarm and drives the buzzer until the user dismisses it or it times out. It sits between the button conditioning logic and the set-time / set-alarm / timekeeping blocks.

---
 rtl/clock_mode_ctrl_if.sv | 31 +++
 rtl/clock_mode_ctrl.sv | 158 +++++++++++++++
 tb/tb_clock_mode_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_mode_ctrl_if.sv
// rtl/clock_mode_ctrl_if.sv - button and setter handshake bundle for clock_mode_ctrl
//
// Purpose: groups the shared buttons, the setters' last-field acks and the
// enables/pulses handed back to the setters.
// Ports (signals):
//   mode_button, inc_button, set_button  debounced button levels
//   time_ack, alarm_ack                  setter is on its last field
//   set_time_en, set_alarm_en            enable to the respective setter
//   mode_pulse, inc_pulse                one-cycle forwarded button events
// Modports: master = button/setter side, slave = mode controller.
interface clock_mode_ctrl_if;
   logic mode_button;
   logic inc_button;
   logic set_button;
   logic time_ack;
   logic alarm_ack;
   logic set_time_en;
   logic set_alarm_en;
   logic mode_pulse;
   logic inc_pulse;

   modport master (
      output mode_button, inc_button, set_button, time_ack, alarm_ack,
      input  set_time_en, set_alarm_en, mode_pulse, inc_pulse
   );

   modport slave (
      input  mode_button, inc_button, set_button, time_ack, alarm_ack,
      output set_time_en, set_alarm_en, mode_pulse, inc_pulse
   );
endinterface

// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - digital clock mode controller with alarm buzzer
//
// Purpose: routes the shared mode/inc/set buttons to the time setter, the
// alarm setter or nobody, compares running time with the stored alarm and
// drives the buzzer until dismissed or timed out.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   sec_tick            one-cycle pulse per second
//   cur_*               running time, BCD digits
//   alm_*               stored alarm, BCD digits
//   on_off_alarm        alarm armed
//   bus (slave)         buttons, setter acks, setter enables, forwarded pulses
//   buzzer              alarm sounding
//   state               0 IDLE, 1 SET_TIME, 2 SET_ALARM, 3 RINGING
module clock_mode_ctrl #(
   parameter int SET_TIMEOUT_S  = 30,
   parameter int RING_TIMEOUT_S = 60
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sec_tick,
   input  logic [1:0]          cur_hours_left,
   input  logic [3:0]          cur_hours_right,
   input  logic [2:0]          cur_minutes_left,
   input  logic [3:0]          cur_minutes_right,
   input  logic [1:0]          alm_hours_left,
   input  logic [3:0]          alm_hours_right,
   input  logic [2:0]          alm_minutes_left,
   input  logic [3:0]          alm_minutes_right,
   input  logic                on_off_alarm,
   clock_mode_ctrl_if.slave    bus,
   output logic                buzzer,
   output logic [1:0]          state
);

   localparam int MAX_TO = (SET_TIMEOUT_S > RING_TIMEOUT_S) ? SET_TIMEOUT_S : RING_TIMEOUT_S;
   localparam int CW     = $clog2(MAX_TO + 1);
   localparam logic [CW-1:0] SET_LAST  = CW'(SET_TIMEOUT_S - 1);
   localparam logic [CW-1:0] RING_LAST = CW'(RING_TIMEOUT_S - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_SET_TIME  = 2'd1,
      ST_SET_ALARM = 2'd2,
      ST_RINGING   = 2'd3
   } state_t;

   state_t          cur_state;
   state_t          nxt_state;
   logic            mode_q;
   logic            inc_q;
   logic            set_q;
   logic            match_q;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic            set_rise;
   logic            mode_rise;
   logic            inc_rise;
   logic            any_rise;
   logic            match;
   logic            match_rise;
   logic            mode_fwd;
   logic            inc_fwd;
   logic            cur_ack;

   assign set_rise   = bus.set_button  & ~set_q;
   assign mode_rise  = bus.mode_button & ~mode_q;
   assign inc_rise   = bus.inc_button  & ~inc_q;
   assign any_rise   = set_rise | mode_rise | inc_rise;

   assign match = on_off_alarm
                & (alm_hours_left    == cur_hours_left)
                & (alm_hours_right   == cur_hours_right)
                & (alm_minutes_left  == cur_minutes_left)
                & (alm_minutes_right == cur_minutes_right);
   assign match_rise = match & ~match_q;

   assign cur_ack = (cur_state == ST_SET_TIME) ? bus.time_ack : bus.alarm_ack;
   assign state   = cur_state;

   always_comb begin
      nxt_state = cur_state;
      mode_fwd  = 1'b0;
      inc_fwd   = 1'b0;
      cnt_nxt   = cnt;

      case (cur_state)
         ST_IDLE: begin
            // Buttons other than set are ignored; a set press beats a
            // simultaneous alarm match, which is then lost.
            if (set_rise)
               nxt_state = ST_SET_TIME;
            else if (match_rise)
               nxt_state = ST_RINGING;
         end
         ST_SET_TIME, ST_SET_ALARM: begin
            // if/else order gives set > mode > inc; a match rise is dropped.
            if (set_rise)
               nxt_state = (cur_state == ST_SET_TIME) ? ST_SET_ALARM : ST_IDLE;
            else if (mode_rise) begin
               mode_fwd = 1'b1;
               if (cur_ack)
                  nxt_state = ST_IDLE;
            end
            else if (inc_rise)
               inc_fwd = 1'b1;
            else if (sec_tick && (cnt == SET_LAST))
               nxt_state = ST_IDLE;
         end
         default: begin
            // Dismiss press is swallowed, never forwarded to a setter.
            if (any_rise)
               nxt_state = ST_IDLE;
            else if (sec_tick && (cnt == RING_LAST))
               nxt_state = ST_IDLE;
         end
      endcase

      // Counts ticks strictly after the last clear; an edge in the same
      // cycle as a tick wins and the tick is not counted.
      if ((nxt_state != cur_state) || any_rise || (cur_state == ST_IDLE))
         cnt_nxt = '0;
      else if (sec_tick)
         cnt_nxt = cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state        <= ST_IDLE;
         // Loading 1 means a held button or an already-true match at
         // reset release produces no edge.
         mode_q           <= 1'b1;
         inc_q            <= 1'b1;
         set_q            <= 1'b1;
         match_q          <= 1'b1;
         cnt              <= '0;
         buzzer           <= 1'b0;
         bus.set_time_en  <= 1'b0;
         bus.set_alarm_en <= 1'b0;
         bus.mode_pulse   <= 1'b0;
         bus.inc_pulse    <= 1'b0;
      end
      else begin
         cur_state        <= nxt_state;
         mode_q           <= bus.mode_button;
         inc_q            <= bus.inc_button;
         set_q            <= bus.set_button;
         match_q          <= match;
         cnt              <= cnt_nxt;
         buzzer           <= (nxt_state == ST_RINGING);
         bus.set_time_en  <= (nxt_state == ST_SET_TIME);
         bus.set_alarm_en <= (nxt_state == ST_SET_ALARM);
         bus.mode_pulse   <= mode_fwd;
         bus.inc_pulse    <= inc_fwd;
      end
   end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb/tb_clock_mode_ctrl.sv - self-checking bench for clock_mode_ctrl
module tb_clock_mode_ctrl;
   localparam int SET_TO  = 2;
   localparam int RING_TO = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       sec_tick;
   logic [1:0] cur_hl, alm_hl;
   logic [3:0] cur_hr, alm_hr;
   logic [2:0] cur_ml, alm_ml;
   logic [3:0] cur_mr, alm_mr;
   logic       on_off_alarm;
   logic       buzzer;
   logic [1:0] dut_state;

   clock_mode_ctrl_if bus ();

   clock_mode_ctrl #(.SET_TIMEOUT_S(SET_TO), .RING_TIMEOUT_S(RING_TO)) dut (
      .clk               (clk),
      .rst               (rst),
      .sec_tick          (sec_tick),
      .cur_hours_left    (cur_hl),
      .cur_hours_right   (cur_hr),
      .cur_minutes_left  (cur_ml),
      .cur_minutes_right (cur_mr),
      .alm_hours_left    (alm_hl),
      .alm_hours_right   (alm_hr),
      .alm_minutes_left  (alm_ml),
      .alm_minutes_right (alm_mr),
      .on_off_alarm      (on_off_alarm),
      .bus               (bus),
      .buzzer            (buzzer),
      .state             (dut_state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model: times kept as plain hour/minute integers
   int cur_h, cur_m, alm_h, alm_m;
   int m_state;
   int ticks;
   bit p_mode, p_inc, p_set, p_match;
   int e_state, e_buzz, e_ten, e_aen, e_mp, e_ip;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_cur(input int h, input int m);
      cur_h = h; cur_m = m;
      cur_hl = 2'(h / 10); cur_hr = 4'(h % 10);
      cur_ml = 3'(m / 10); cur_mr = 4'(m % 10);
   endtask

   task automatic set_alm(input int h, input int m);
      alm_h = h; alm_m = m;
      alm_hl = 2'(h / 10); alm_hr = 4'(h % 10);
      alm_ml = 3'(m / 10); alm_mr = 4'(m % 10);
   endtask

   task automatic model_update();
      bit se, me, ie, any_e, mt, rise;
      int ns;
      int mp, ip;
      mp = 0; ip = 0;
      if (rst) begin
         m_state = 0; ticks = 0;
         p_mode = 1; p_inc = 1; p_set = 1; p_match = 1;
      end
      else begin
         se = bus.set_button  && !p_set;
         me = bus.mode_button && !p_mode;
         ie = bus.inc_button  && !p_inc;
         any_e = se || me || ie;
         mt = on_off_alarm && (cur_h == alm_h) && (cur_m == alm_m);
         rise = mt && !p_match;
         ns = m_state;
         if (m_state == 0) begin
            if (se) ns = 1;
            else if (rise) ns = 3;
         end
         else if (m_state == 3) begin
            if (any_e) ns = 0;
            else if (sec_tick && ticks + 1 == RING_TO) ns = 0;
         end
         else begin
            if (se) ns = (m_state == 1) ? 2 : 0;
            else if (me) begin
               mp = 1;
               if ((m_state == 1) ? bus.time_ack : bus.alarm_ack) ns = 0;
            end
            else if (ie) ip = 1;
            else if (sec_tick && ticks + 1 == SET_TO) ns = 0;
         end
         if (ns != m_state || any_e || ns == 0) ticks = 0;
         else if (sec_tick) ticks++;
         p_set = bus.set_button; p_mode = bus.mode_button; p_inc = bus.inc_button;
         p_match = mt;
         m_state = ns;
      end
      e_state = m_state;
      e_buzz  = (m_state == 3) ? 1 : 0;
      e_ten   = (m_state == 1) ? 1 : 0;
      e_aen   = (m_state == 2) ? 1 : 0;
      e_mp    = mp;
      e_ip    = ip;
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      check("state",        32'(dut_state),        32'(e_state));
      check("buzzer",       32'(buzzer),           32'(e_buzz));
      check("set_time_en",  32'(bus.set_time_en),  32'(e_ten));
      check("set_alarm_en", 32'(bus.set_alarm_en), 32'(e_aen));
      check("mode_pulse",   32'(bus.mode_pulse),   32'(e_mp));
      check("inc_pulse",    32'(bus.inc_pulse),    32'(e_ip));
   endtask

   task automatic tick();
      sec_tick = 1'b1; step(); sec_tick = 1'b0;
   endtask

   initial begin
      rst = 1'b1; sec_tick = 1'b0; on_off_alarm = 1'b0;
      bus.mode_button = 1'b1; bus.inc_button = 1'b1; bus.set_button = 1'b1;
      bus.time_ack = 1'b0; bus.alarm_ack = 1'b0;
      set_cur(12, 0); set_alm(7, 30);

      // reset with buttons held, release keeping them held
      repeat (3) step();
      check("reset_state", 32'(dut_state), 32'd0);
      rst = 1'b0;
      repeat (2) step();
      check("held_state", 32'(dut_state), 32'd0);
      check("held_mode_pulse", 32'(bus.mode_pulse), 32'd0);
      check("held_inc_pulse", 32'(bus.inc_pulse), 32'd0);
      bus.mode_button = 1'b0; bus.inc_button = 1'b0; bus.set_button = 1'b0;
      step();

      // set -> SET_TIME, three incs, set -> SET_ALARM, set -> IDLE
      bus.set_button = 1'b1; step();
      check("enter_set_time", 32'(dut_state), 32'd1);
      check("set_time_en_rise", 32'(bus.set_time_en), 32'd1);
      check("no_pulse_on_entry", 32'(bus.mode_pulse | bus.inc_pulse), 32'd0);
      bus.set_button = 1'b0; step();
      for (int i = 0; i < 3; i++) begin
         bus.inc_button = 1'b1; step();
         check("inc_press_pulse", 32'(bus.inc_pulse), 32'd1);
         step();
         check("inc_held_no_pulse", 32'(bus.inc_pulse), 32'd0);
         bus.inc_button = 1'b0; step();
      end
      bus.set_button = 1'b1; step();
      check("enter_set_alarm", 32'(dut_state), 32'd2);
      check("set_alarm_en_rise", 32'(bus.set_alarm_en), 32'd1);
      bus.set_button = 1'b0; step();
      bus.set_button = 1'b1; step();
      check("alarm_set_to_idle", 32'(dut_state), 32'd0);
      bus.set_button = 1'b0; step();

      // SET_TIME, ack on last field, mode leaves with one pulse
      bus.set_button = 1'b1; step();
      bus.set_button = 1'b0; step();
      bus.time_ack = 1'b1;
      bus.mode_button = 1'b1; step();
      check("ack_mode_pulse", 32'(bus.mode_pulse), 32'd1);
      check("ack_en_fall", 32'(bus.set_time_en), 32'd0);
      check("ack_state", 32'(dut_state), 32'd0);
      bus.mode_button = 1'b0; step();
      check("ack_pulse_single", 32'(bus.mode_pulse), 32'd0);
      bus.time_ack = 1'b0;

      // alarm 07:30 armed
      on_off_alarm = 1'b1;
      set_cur(7, 29); step();
      set_cur(7, 30); step();
      check("alarm_rings", 32'(buzzer), 32'd1);
      step();
      bus.inc_button = 1'b1; step();
      check("dismiss_buzzer", 32'(buzzer), 32'd0);
      check("dismiss_no_inc", 32'(bus.inc_pulse), 32'd0);
      bus.inc_button = 1'b0; step();
      check("dismiss_no_inc2", 32'(bus.inc_pulse), 32'd0);

      // disarmed: same transition stays silent
      on_off_alarm = 1'b0;
      set_cur(7, 29); step();
      set_cur(7, 30); step();
      check("disarmed_silent", 32'(buzzer), 32'd0);

      // ring timeout after 3rd tick
      on_off_alarm = 1'b1;
      set_cur(7, 29); step();
      set_cur(7, 30); step();
      check("ring_start", 32'(buzzer), 32'd1);
      tick(); step(); tick(); step();
      check("ring_after_2", 32'(buzzer), 32'd1);
      tick();
      check("ring_timeout", 32'(buzzer), 32'd0);
      set_cur(8, 0); step();

      // set timeout in SET_ALARM with an inc after the first tick
      bus.set_button = 1'b1; step(); bus.set_button = 1'b0; step();
      bus.set_button = 1'b1; step(); bus.set_button = 1'b0; step();
      tick();
      bus.inc_button = 1'b1; step(); bus.inc_button = 1'b0; step();
      tick();
      check("set_to_after_2", 32'(dut_state), 32'd2);
      tick();
      check("set_to_exit", 32'(dut_state), 32'd0);

      // simultaneous set+mode+inc in SET_TIME
      bus.set_button = 1'b1; step(); bus.set_button = 1'b0; step();
      bus.set_button = 1'b1; bus.mode_button = 1'b1; bus.inc_button = 1'b1; step();
      check("simul_state", 32'(dut_state), 32'd2);
      check("simul_no_mode", 32'(bus.mode_pulse), 32'd0);
      check("simul_no_inc", 32'(bus.inc_pulse), 32'd0);
      bus.set_button = 1'b0; bus.mode_button = 1'b0; bus.inc_button = 1'b0; step();
      bus.set_button = 1'b1; step(); bus.set_button = 1'b0; step();

      // reset mid-ring; a match true at release does not ring
      set_cur(7, 29); step();
      set_cur(7, 30); step();
      check("ring_before_rst", 32'(buzzer), 32'd1);
      rst = 1'b1; step();
      check("rst_mid_ring", 32'(buzzer), 32'd0);
      rst = 1'b0; step(); step();
      check("no_ring_after_rst", 32'(buzzer), 32'd0);

      // randomized phase against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(5) == 0) bus.set_button  = ~bus.set_button;
         if ($urandom_range(4) == 0) bus.mode_button = ~bus.mode_button;
         if ($urandom_range(4) == 0) bus.inc_button  = ~bus.inc_button;
         bus.time_ack  = 1'($urandom_range(1));
         bus.alarm_ack = 1'($urandom_range(1));
         sec_tick = ($urandom_range(3) == 0);
         on_off_alarm = ($urandom_range(7) != 0);
         rst = ($urandom_range(399) == 0);
         case ($urandom_range(7))
            0: set_cur(7, 29);
            1: set_cur(7, 30);
            2: set_cur(int'($urandom_range(23)), int'($urandom_range(59)));
            default: ;
         endcase
         if ($urandom_range(199) == 0) set_alm(int'($urandom_range(23)), int'($urandom_range(59)));
         if ($urandom_range(99) == 0) set_alm(cur_h, cur_m);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
